// File: rtl/seg7_scan_decoder_pkg.sv
// Shared 7-segment definitions: code table, segment bit positions, scan FSM
// states and the per-digit capture record. The encoder side reuses the same
// constants, so that both ends of a loop-back test agree on the patterns.
package seg7_scan_decoder_pkg;

    localparam int unsigned SEG_W = 7;

    // Segment bit positions within the active-low seg_n bus
    localparam int unsigned SEG_A_BIT = 6;
    localparam int unsigned SEG_B_BIT = 5;
    localparam int unsigned SEG_C_BIT = 4;
    localparam int unsigned SEG_D_BIT = 3;
    localparam int unsigned SEG_E_BIT = 2;
    localparam int unsigned SEG_F_BIT = 1;
    localparam int unsigned SEG_G_BIT = 0;

    // Active-low patterns, bit6=a .. bit0=g
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Scan FSM state encodings
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_e;

    // What was recovered from one digit
    typedef struct packed {
        logic [3:0] nibble;
        logic       err;
        logic       blank;
    } digit_info_t;

    // Encoder-side helper: nibble to active-low segment pattern
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] nib);
        logic [SEG_W-1:0] pat;
        case (nib)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_pattern_decode.sv
// seg7_pattern_decode: combinational reverse lookup of one active-low segment
// pattern. Ports:
//   pattern_i  7-bit active-low segment pattern (bit6=a .. bit0=g)
//   nibble_o   recovered hex value (0 for blank or unknown patterns)
//   blank_o    pattern is all segments off
//   err_o      pattern is neither a hex glyph nor blank
module seg7_pattern_decode
    import seg7_scan_decoder_pkg::*;
(
    input  logic [SEG_W-1:0] pattern_i,
    output logic [3:0]       nibble_o,
    output logic             blank_o,
    output logic             err_o
);

    // Table lookup; anything unrecognised flags an error and reads as 0
    always_comb begin
        nibble_o = 4'h0;
        blank_o  = 1'b0;
        err_o    = 1'b0;
        case (pattern_i)
            SEG_0:     nibble_o = 4'h0;
            SEG_1:     nibble_o = 4'h1;
            SEG_2:     nibble_o = 4'h2;
            SEG_3:     nibble_o = 4'h3;
            SEG_4:     nibble_o = 4'h4;
            SEG_5:     nibble_o = 4'h5;
            SEG_6:     nibble_o = 4'h6;
            SEG_7:     nibble_o = 4'h7;
            SEG_8:     nibble_o = 4'h8;
            SEG_9:     nibble_o = 4'h9;
            SEG_A:     nibble_o = 4'hA;
            SEG_B:     nibble_o = 4'hB;
            SEG_C:     nibble_o = 4'hC;
            SEG_D:     nibble_o = 4'hD;
            SEG_E:     nibble_o = 4'hE;
            SEG_F:     nibble_o = 4'hF;
            SEG_BLANK: blank_o  = 1'b1;
            default:   err_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: watches a multiplexed active-low 7-segment bus and
// rebuilds the value shown across all digits once per scan frame.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   seg_n        segment lines, active-low (bit6=a .. bit0=g)
//   an_n         digit strobes, active-low, bit0 = least-significant digit
//   value        last completed frame, digit k in bits [4k+3:4k]
//   value_valid  one-cycle pulse when value/digit_err/blank update
//   digit_err    per-digit unknown-pattern flags of the last frame
//   blank        per-digit blank flags of the last frame
//   timeout      one-cycle pulse when a partial frame is dropped
module seg7_scan_decoder
    import seg7_scan_decoder_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEG_W-1:0]      seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    output logic [DIGITS-1:0]     digit_err,
    output logic [DIGITS-1:0]     blank,
    output logic                  timeout
);

    localparam int unsigned VAL_W  = 4 * DIGITS;
    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // True when exactly one strobe is low
    function automatic logic single_strobe(input logic [DIGITS-1:0] an);
        logic found;
        logic multi;
        found = 1'b0;
        multi = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (!an[k]) begin
                if (found) multi = 1'b1;
                found = 1'b1;
            end
        end
        return found && !multi;
    endfunction

    // Index of the (single) low strobe
    function automatic logic [IDX_W-1:0] strobe_index(input logic [DIGITS-1:0] an);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (!an[k]) idx = IDX_W'(k);
        end
        return idx;
    endfunction

    // Two-flop synchronizers, idle bus (all high) out of reset
    logic [SEG_W-1:0]  seg_s1_q, seg_s2_q;
    logic [DIGITS-1:0] an_s1_q,  an_s2_q;

    // Previous synchronized pair, used for change detection and capture
    logic [SEG_W-1:0]  seg_prev_q;
    logic [DIGITS-1:0] an_prev_q;

    scan_state_e                      state_q, state_d;
    logic [STAB_W-1:0]                stab_cnt_q, stab_cnt_d;
    digit_info_t [DIGITS-1:0]         shadow_q, shadow_d;
    logic [DIGITS-1:0]                seen_q, seen_d;
    logic [TMO_W-1:0]                 tmo_cnt_q, tmo_cnt_d;
    logic [VAL_W-1:0]                 value_q, value_d;
    logic [DIGITS-1:0]                err_q, err_d;
    logic [DIGITS-1:0]                blank_q, blank_d;
    logic                             valid_q, valid_d;
    logic                             timeout_q, timeout_d;

    logic             pair_changed_c;
    logic             cur_single_c;
    logic             capture_c;
    logic             frame_done_c;
    logic [IDX_W-1:0] cap_idx_c;
    logic [3:0]       dec_nibble_c;
    logic             dec_blank_c;
    logic             dec_err_c;

    // Decode the pair that has been held stable, not the newest sample
    seg7_pattern_decode u_decode (
        .pattern_i (seg_prev_q),
        .nibble_o  (dec_nibble_c),
        .blank_o   (dec_blank_c),
        .err_o     (dec_err_c)
    );

    assign pair_changed_c = (an_s2_q != an_prev_q) || (seg_s2_q != seg_prev_q);
    assign cur_single_c   = single_strobe(an_s2_q);
    assign cap_idx_c      = strobe_index(an_prev_q);
    assign capture_c      = (state_q == ST_SETTLE) && (stab_cnt_q == STAB_W'(STABLE_CYCLES));
    assign frame_done_c   = &seen_q;

    // Next-state: scan FSM, shadow capture, frame assembly and timeout
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        shadow_d   = shadow_q;
        seen_d     = seen_q;
        tmo_cnt_d  = tmo_cnt_q;
        value_d    = value_q;
        err_d      = err_q;
        blank_d    = blank_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;

        // A pair change always restarts qualification, even in the capture cycle
        if (pair_changed_c) begin
            if (cur_single_c) begin
                state_d    = ST_SETTLE;
                stab_cnt_d = STAB_W'(1);
            end else begin
                state_d    = ST_IDLE;
                stab_cnt_d = '0;
            end
        end else if (capture_c) begin
            state_d = ST_HELD;
        end else if (state_q == ST_SETTLE) begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end

        if (frame_done_c) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                value_d[4*k +: 4] = shadow_q[k].nibble;
                err_d[k]          = shadow_q[k].err;
                blank_d[k]        = shadow_q[k].blank;
            end
            valid_d   = 1'b1;
            seen_d    = '0;
            tmo_cnt_d = '0;
        end else if (seen_q != '0) begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                seen_d    = '0;
                tmo_cnt_d = '0;
                timeout_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end

        // Applied after the frame clear so a coincident capture opens the next frame
        if (capture_c) begin
            shadow_d[cap_idx_c].nibble = dec_nibble_c;
            shadow_d[cap_idx_c].err    = dec_err_c;
            shadow_d[cap_idx_c].blank  = dec_blank_c;
            seen_d[cap_idx_c]          = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q   <= SEG_BLANK;
            seg_s2_q   <= SEG_BLANK;
            an_s1_q    <= '1;
            an_s2_q    <= '1;
            seg_prev_q <= SEG_BLANK;
            an_prev_q  <= '1;
            state_q    <= ST_IDLE;
            stab_cnt_q <= '0;
            shadow_q   <= '0;
            seen_q     <= '0;
            tmo_cnt_q  <= '0;
            value_q    <= '0;
            err_q      <= '0;
            blank_q    <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            seg_s1_q   <= seg_n;
            seg_s2_q   <= seg_s1_q;
            an_s1_q    <= an_n;
            an_s2_q    <= an_s1_q;
            seg_prev_q <= seg_s2_q;
            an_prev_q  <= an_s2_q;
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            shadow_q   <= shadow_d;
            seen_q     <= seen_d;
            tmo_cnt_q  <= tmo_cnt_d;
            value_q    <= value_d;
            err_q      <= err_d;
            blank_q    <= blank_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign digit_err   = err_q;
    assign blank       = blank_q;
    assign timeout     = timeout_q;

endmodule
